branch_ctrl: RTL and testbench

- Sequences branch/jump resolution for the 5-stage RV32I core.
- Accepts one control-transfer op from ID via a valid/ready handshake and waits for hazard-free operands.
- Evaluates the condition through the shared 32-bit comparator `cmp_32`, computes the target, and compares the outcome against the fetch prediction.
- On mispredict, issues a redirect/flush to IF and holds it until IF acknowledges.

---
 rtl/branch_pkg.sv | 27 ++
 rtl/branch_ctrl_cmp_32.sv | 43 ++++
 rtl/branch_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_branch_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution block.
//   - Condition-code encodings (funct3 of RV32I branches)
//   - req_kind encodings
//   - FSM state type used by branch_ctrl
package branch_pkg;

    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NE  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b100;
    localparam logic [2:0] CMP_GE  = 3'b101;
    localparam logic [2:0] CMP_LTU = 3'b110;
    localparam logic [2:0] CMP_GEU = 3'b111;

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JAL    = 2'b01;
    localparam logic [1:0] KIND_JALR   = 2'b10;
    localparam logic [1:0] KIND_NOP    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_OPND,
        ST_RESOLVE,
        ST_REDIRECT,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/branch_ctrl_cmp_32.sv
// cmp_32: shared comparator evaluating one RV32I branch condition.
// Ports:
//   a, b  : operands (rs1, rs2)
//   code  : condition code (EQ/NE/LT/GE/LTU/GEU); 010/011 yield 0
//   cond  : result of the selected condition only
module cmp_32
    import branch_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        code,
    output logic              cond
);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic                     eq;
    logic                     lt_s;
    logic                     lt_u;

    assign a_s  = a;
    assign b_s  = b;
    assign eq   = (a == b);
    assign lt_s = (a_s < b_s);
    assign lt_u = (a < b);

    // Each code selects exactly one primitive; no OR-ing of terms across codes.
    always_comb begin
        cond = 1'b0;
        case (code)
            CMP_EQ:  cond = eq;
            CMP_NE:  cond = ~eq;
            CMP_LT:  cond = lt_s;
            CMP_GE:  cond = ~lt_s;
            CMP_LTU: cond = lt_u;
            CMP_GEU: cond = ~lt_u;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves one branch/jump at a time for the 5-stage RV32I core.
// Accepts an op from ID (valid/ready), waits for forwardable operands,
// evaluates the condition and target, and on a mispredict holds a redirect
// to IF until acknowledged, then raises flush for FLUSH_CYCLES cycles.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         ID handshake
//   req_kind, req_cmp           op kind and condition code
//   req_pc, req_imm             op PC and sign-extended immediate
//   req_pred_taken/req_pred_pc  fetch prediction
//   opnd_busy, rs1_data, rs2_data  operand availability and values
//   redirect_valid/pc/ack       refetch request to IF
//   flush                       squash younger instructions
//   res_valid, res_taken        one-cycle resolution pulse and direction
//
// Optional feature, macro BRANCH_STATS_EN: adds saturating 32-bit counters
// stat_resolved, stat_taken, stat_mispredict.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic [2:0]      req_cmp,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_imm,
    input  logic            req_pred_taken,
    input  logic [XLEN-1:0] req_pred_pc,
    input  logic            opnd_busy,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ack,
    output logic            flush,
    output logic            res_valid,
    output logic            res_taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_resolved,
    output logic [31:0]     stat_taken,
    output logic [31:0]     stat_mispredict
`endif
);

    localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic [1:0]        op_kind;
    logic [2:0]        op_cmp;
    logic [XLEN-1:0]   op_pc;
    logic [XLEN-1:0]   op_imm;
    logic              op_pred_taken;
    logic [XLEN-1:0]   op_pred_pc;
    logic [XLEN-1:0]   op_rs1;
    logic [XLEN-1:0]   op_rs2;

    logic              accept;
    logic              opnd_load;
    logic              cond;
    logic              taken;
    logic [XLEN-1:0]   sum_pc;
    logic [XLEN-1:0]   sum_jalr;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   correct_pc;
    logic              mispredict;

    assign accept    = (state == ST_IDLE) && req_valid;
    // Operands are taken in the accept cycle if already forwardable,
    // otherwise in the first non-busy cycle of WAIT_OPND.
    assign opnd_load = (accept || (state == ST_WAIT_OPND)) && !opnd_busy;

    // Op capture (data path, no reset needed)
    always_ff @(posedge clk) begin
        if (accept) begin
            op_kind       <= req_kind;
            op_cmp        <= req_cmp;
            op_pc         <= req_pc;
            op_imm        <= req_imm;
            op_pred_taken <= req_pred_taken;
            op_pred_pc    <= req_pred_pc;
        end
        if (opnd_load) begin
            op_rs1 <= rs1_data;
            op_rs2 <= rs2_data;
        end
    end

    cmp_32 #(
        .DATA_W (XLEN)
    ) u_cmp (
        .a    (op_rs1),
        .b    (op_rs2),
        .code (op_cmp),
        .cond (cond)
    );

    // Resolution: direction, target and prediction check
    always_comb begin
        sum_pc   = op_pc + op_imm;
        sum_jalr = op_rs1 + op_imm;
        target   = (op_kind == KIND_JALR) ? {sum_jalr[XLEN-1:1], 1'b0} : sum_pc;
        case (op_kind)
            KIND_BRANCH: taken = cond;
            KIND_JAL:    taken = 1'b1;
            KIND_JALR:   taken = 1'b1;
            default:     taken = 1'b0;
        endcase
        correct_pc = taken ? target : (op_pc + XLEN'(4));
        mispredict = (taken != op_pred_taken) || (taken && (target != op_pred_pc));
    end

    // Control state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            flush_cnt   <= '0;
            redirect_pc <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= cnt_nxt;
            if ((state == ST_RESOLVE) && mispredict) begin
                redirect_pc <= correct_pc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = flush_cnt;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = opnd_busy ? ST_WAIT_OPND : ST_RESOLVE;
                end
            end
            ST_WAIT_OPND: begin
                if (!opnd_busy) begin
                    state_nxt = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                state_nxt = mispredict ? ST_REDIRECT : ST_IDLE;
            end
            ST_REDIRECT: begin
                if (redirect_ack) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_FLUSH;
                        cnt_nxt   = FLUSH_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                // Leaving on the count of 1 keeps flush high for exactly
                // FLUSH_CYCLES cycles.
                cnt_nxt = flush_cnt - CNT_W'(1);
                if (flush_cnt <= CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign req_ready      = (state == ST_IDLE);
    assign redirect_valid = (state == ST_REDIRECT);
    assign flush          = (state == ST_FLUSH);
    assign res_valid      = (state == ST_RESOLVE);
    assign res_taken      = (state == ST_RESOLVE) && taken;

`ifdef BRANCH_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved   <= '0;
            stat_taken      <= '0;
            stat_mispredict <= '0;
        end else if (state == ST_RESOLVE) begin
            stat_resolved <= sat_inc(stat_resolved);
            if (taken) begin
                stat_taken <= sat_inc(stat_taken);
            end
            if (mispredict) begin
                stat_mispredict <= sat_inc(stat_mispredict);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed ops with a scoreboard of
// expected resolutions; redirect, flush and latency checked inline.
module tb_branch_ctrl;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [2:0]  req_cmp;
    logic [31:0] req_pc;
    logic [31:0] req_imm;
    logic        req_pred_taken;
    logic [31:0] req_pred_pc;
    logic        opnd_busy;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ack;
    logic        flush;
    logic        res_valid;
    logic        res_taken;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_taken;
    logic [31:0] stat_mispredict;
`endif

    always #5 clk = ~clk;

    branch_ctrl #(
        .XLEN         (32),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_kind       (req_kind),
        .req_cmp        (req_cmp),
        .req_pc         (req_pc),
        .req_imm        (req_imm),
        .req_pred_taken (req_pred_taken),
        .req_pred_pc    (req_pred_pc),
        .opnd_busy      (opnd_busy),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ack   (redirect_ack),
        .flush          (flush),
        .res_valid      (res_valid),
        .res_taken      (res_taken)
`ifdef BRANCH_STATS_EN
        ,
        .stat_resolved   (stat_resolved),
        .stat_taken      (stat_taken),
        .stat_mispredict (stat_mispredict)
`endif
    );

    typedef struct packed {
        logic        taken;
        logic        mis;
        logic [31:0] cpc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model of one resolution
    function automatic exp_t model(input logic [1:0] kind, input logic [2:0] cmp,
                                   input logic [31:0] pc, input logic [31:0] imm,
                                   input logic pt, input logic [31:0] ppc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic        c;
        logic [31:0] tgt;
        int signed   s1;
        int signed   s2;
        s1 = r1;
        s2 = r2;
        case (cmp)
            3'b000:  c = (r1 == r2);
            3'b001:  c = (r1 != r2);
            3'b100:  c = (s1 < s2);
            3'b101:  c = (s1 >= s2);
            3'b110:  c = (r1 < r2);
            3'b111:  c = (r1 >= r2);
            default: c = 1'b0;
        endcase
        case (kind)
            2'b00: begin e.taken = c;    tgt = pc + imm; end
            2'b01: begin e.taken = 1'b1; tgt = pc + imm; end
            2'b10: begin e.taken = 1'b1; tgt = (r1 + imm) & 32'hFFFF_FFFE; end
            default: begin e.taken = 1'b0; tgt = pc + imm; end
        endcase
        e.cpc = e.taken ? tgt : pc + 32'd4;
        e.mis = (e.taken != pt) || (e.taken && (tgt != ppc));
        return e;
    endfunction

    // Scoreboard side: every resolution pulse pops one expectation
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("res_taken", {31'd0, res_taken}, {31'd0, e.taken});
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"},  {31'd0, req_ready},      32'd1);
        chk({tag, "_resv"},   {31'd0, res_valid},      32'd0);
        chk({tag, "_rest"},   {31'd0, res_taken},      32'd0);
        chk({tag, "_rdv"},    {31'd0, redirect_valid}, 32'd0);
        chk({tag, "_rdpc"},   redirect_pc,             32'd0);
        chk({tag, "_flush"},  {31'd0, flush},          32'd0);
    endtask

    task automatic do_op(input logic [1:0] kind, input logic [2:0] cmp,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ppc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input int busy, input int ack_dly, input bit abort);
        exp_t e;
        int   n;
        e = model(kind, cmp, pc, imm, pt, ppc, r1, r2);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before", {31'd0, req_ready}, 32'd1);
        req_valid      = 1'b1;
        req_kind       = kind;
        req_cmp        = cmp;
        req_pc         = pc;
        req_imm        = imm;
        req_pred_taken = pt;
        req_pred_pc    = ppc;
        opnd_busy      = (busy > 0);
        rs1_data       = (busy > 0) ? 32'hAAAA_AAAA : r1;
        rs2_data       = (busy > 0) ? 32'h5555_5555 : r2;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_pc    = 32'hDEAD_0000;
        req_imm   = 32'h0000_0FF0;
        req_cmp   = 3'b001;
        for (int i = 0; i < busy; i++) begin
            chk("ready_wait", {31'd0, req_ready}, 32'd0);
            chk("resv_wait",  {31'd0, res_valid}, 32'd0);
            @(negedge clk);
        end
        if (busy > 0) begin
            opnd_busy = 1'b0;
            rs1_data  = r1;
            rs2_data  = r2;
            @(negedge clk);
        end
        chk("res_latency", {31'd0, res_valid}, 32'd1);
        chk("ready_res",   {31'd0, req_ready}, 32'd0);
        rs1_data = 32'h1234_5678;
        rs2_data = 32'h8765_4321;
        @(negedge clk);
        chk("res_pulse", {31'd0, res_valid}, 32'd0);
        if (e.mis) begin
            for (int i = 0; i < ack_dly; i++) begin
                chk("rdv_hold", {31'd0, redirect_valid}, 32'd1);
                chk("rdpc_hold", redirect_pc, e.cpc);
                chk("flush_early", {31'd0, flush}, 32'd0);
                @(negedge clk);
            end
            chk("rdv", {31'd0, redirect_valid}, 32'd1);
            chk("rdpc", redirect_pc, e.cpc);
            redirect_ack = 1'b1;
            @(negedge clk);
            redirect_ack = 1'b0;
            chk("rdv_drop", {31'd0, redirect_valid}, 32'd0);
            chk("flush_rise", {31'd0, flush}, 32'd1);
            if (abort) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_idle_outputs("abort");
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("abort_no_rdv", {31'd0, redirect_valid}, 32'd0);
                    chk("abort_no_flush", {31'd0, flush}, 32'd0);
                end
            end else begin
                n = 0;
                while (flush && n < 10) begin
                    n++;
                    @(negedge clk);
                end
                chk("flush_len", n, 32'd2);
                chk("ready_after_flush", {31'd0, req_ready}, 32'd1);
            end
        end else begin
            chk("no_rdv", {31'd0, redirect_valid}, 32'd0);
            chk("no_flush", {31'd0, flush}, 32'd0);
            chk("ready_after", {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_kind       = 2'b00;
        req_cmp        = 3'b000;
        req_pc         = '0;
        req_imm        = '0;
        req_pred_taken = 1'b0;
        req_pred_pc    = '0;
        opnd_busy      = 1'b0;
        rs1_data       = '0;
        rs2_data       = '0;
        redirect_ack   = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // BEQ taken, correctly predicted
        do_op(KIND_BRANCH, CMP_EQ, 32'h100, 32'h20, 1'b1, 32'h120, 32'd5, 32'd2 + 32'd3, 0, 0, 1'b0);
        // BEQ not taken, predicted taken -> redirect to pc+4, ack on entry
        do_op(KIND_BRANCH, CMP_EQ, 32'h100, 32'h20, 1'b1, 32'h120, 32'd1, 32'd2, 0, 0, 1'b0);
        // Signed vs unsigned with rs1 = -1, rs2 = 1; predicted not taken
        do_op(KIND_BRANCH, CMP_LT,  32'h200, 32'hFFFF_FFF0, 1'b0, 32'h204, 32'hFFFF_FFFF, 32'd1, 0, 1, 1'b0);
        do_op(KIND_BRANCH, CMP_LTU, 32'h200, 32'hFFFF_FFF0, 1'b0, 32'h204, 32'hFFFF_FFFF, 32'd1, 0, 0, 1'b0);
        do_op(KIND_BRANCH, CMP_GE,  32'h200, 32'hFFFF_FFF0, 1'b0, 32'h204, 32'hFFFF_FFFF, 32'd1, 0, 0, 1'b0);
        do_op(KIND_BRANCH, CMP_GEU, 32'h200, 32'hFFFF_FFF0, 1'b0, 32'h204, 32'hFFFF_FFFF, 32'd1, 0, 2, 1'b0);
        // JALR target with bit 0 cleared, wrong predicted target
        do_op(KIND_JALR, CMP_EQ, 32'h300, 32'd2, 1'b1, 32'h0, 32'h1001, 32'd0, 0, 0, 1'b0);
        // Operands busy for 3 cycles after accept; early values would flip BNE
        do_op(KIND_BRANCH, CMP_NE, 32'h500, 32'h40, 1'b0, 32'h504, 32'd3, 32'd3, 3, 0, 1'b0);
        // Reserved kind predicted taken -> redirect to pc+4
        do_op(KIND_NOP, CMP_EQ, 32'h600, 32'h40, 1'b1, 32'h640, 32'd9, 32'd9, 0, 0, 1'b0);
        // Undefined condition code 010 never taken
        do_op(KIND_BRANCH, 3'b010, 32'h680, 32'h40, 1'b0, 32'h684, 32'd9, 32'd9, 0, 0, 1'b0);
        // JAL target wraps modulo 2^32
        do_op(KIND_JAL, CMP_EQ, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10, 32'd0, 32'd0, 1, 0, 1'b0);
        // Delayed ack, then reset during FLUSH
        do_op(KIND_JAL, CMP_EQ, 32'h400, 32'h80, 1'b0, 32'h404, 32'd0, 32'd0, 0, 5, 1'b1);
        // Block keeps working after the aborted op
        do_op(KIND_BRANCH, CMP_NE, 32'h700, 32'h8, 1'b1, 32'h708, 32'd7, 32'd8, 0, 0, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
